lsu_access_controller: RTL and testbench

//  Multi-cycle sequencer between the core's load/store request and a word-wide data-memory port.

---
 rtl/lsu_access_controller.sv | 180 ++++++++++++++++++
 tb/tb_lsu_access_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_access_controller.sv
// Load/store sequencer: one access at a time, lane-aligned strobes/data, extended load result. Split beats under LSU_MISALIGN_SPLIT_EN.
// Latency: accept at T, response at T+3 (T+5 split, T+1 for errors); stores wait for the write ack.
// Backpressure: req_ready_o only in IDLE; mem outputs held until mem_gnt_i; response held until rsp_ready_i.
module lsu_access_controller #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      req_type_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("lsu_access_controller supports only XLEN=32");
  end

  // load_store_type_e encoding; codes 8..15 are non-memory types
  localparam logic [3:0] L_B = 4'd0, L_BU = 4'd1, L_H = 4'd2, L_HU = 4'd3,
                         L_W = 4'd4, S_B = 4'd5, S_H = 4'd6, S_W = 4'd7;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ISSUE2, WAIT2, RESP} state_e;

  function automatic logic is_mem(input logic [3:0] t);
    return t <= S_W;
  endfunction

  function automatic logic is_store(input logic [3:0] t);
    return (t >= S_B) && (t <= S_W);
  endfunction

  function automatic logic [1:0] size_of(input logic [3:0] t);
    case (t)
      L_B, L_BU, S_B: return 2'd0;
      L_H, L_HU, S_H: return 2'd1;
      default:        return 2'd2;
    endcase
  endfunction

  function automatic logic misaligned(input logic [3:0] t, input logic [1:0] off);
    case (size_of(t))
      2'd1:    return off[0];
      2'd2:    return off != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      type_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic            err_q;
  logic [1:0]      off;
  logic [3:0]      mask;
  logic            accept, acc_err, cap_final;
  logic [3:0]      beat_be;
  logic [XLEN-1:0] beat_addr, beat_wdata, rd_shift, load_data;

  assign off    = addr_q[1:0];
  assign accept = (state_q == IDLE) && req_valid_i;
  assign mask   = (size_of(type_q) == 2'd0) ? 4'b0001 :
                  (size_of(type_q) == 2'd1) ? 4'b0011 : 4'b1111;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic            cap_first, beat2;
  logic [XLEN-1:0] rdata1_q;
  logic [7:0]      be_wide;
  logic [63:0]     wdata_wide, rd_pair;

  assign acc_err    = !is_mem(req_type_i);
  assign beat2      = (state_q == ISSUE2);
  assign be_wide    = {4'b0000, mask} << off;
  assign wdata_wide = {32'b0, wdata_q} << {off, 3'b000};
  assign beat_be    = beat2 ? be_wide[7:4] : be_wide[3:0];
  assign beat_wdata = beat2 ? wdata_wide[63:32] : wdata_wide[31:0];
  assign beat_addr  = {addr_q[XLEN-1:2], 2'b00} + (beat2 ? 32'd4 : 32'd0);
  assign rd_pair    = (state_q == WAIT2) ? {mem_rdata_i, rdata1_q} : {32'b0, mem_rdata_i};
  assign rd_shift   = 32'(rd_pair >> {off, 3'b000});
  assign cap_first  = (state_q == WAIT) && mem_rvalid_i && misaligned(type_q, off);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        rdata1_q <= '0;
    else if (cap_first) rdata1_q <= mem_rdata_i;
  end
`else
  assign acc_err    = !is_mem(req_type_i) || misaligned(req_type_i, req_addr_i[1:0]);
  assign beat_be    = 4'(mask << off);
  assign beat_wdata = wdata_q << {off, 3'b000};
  assign beat_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign rd_shift   = mem_rdata_i >> {off, 3'b000};
`endif

  always_comb begin
    load_data = '0;
    if (!is_store(type_q)) begin
      case (size_of(type_q))
        2'd0:    load_data = (type_q == L_BU) ? {24'b0, rd_shift[7:0]}
                                              : {{24{rd_shift[7]}}, rd_shift[7:0]};
        2'd1:    load_data = (type_q == L_HU) ? {16'b0, rd_shift[15:0]}
                                              : {{16{rd_shift[15]}}, rd_shift[15:0]};
        default: load_data = rd_shift;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cap_final = 1'b0;
    case (state_q)
      IDLE:   if (req_valid_i) state_d = acc_err ? RESP : ISSUE;
      ISSUE:  if (mem_gnt_i) state_d = WAIT;
      WAIT:   if (mem_rvalid_i) begin
                state_d   = RESP;
                cap_final = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
                if (misaligned(type_q, off)) begin
                  state_d   = ISSUE2;
                  cap_final = 1'b0;
                end
`endif
              end
      ISSUE2: if (mem_gnt_i) state_d = WAIT2;
      WAIT2:  if (mem_rvalid_i) begin
                state_d   = RESP;
                cap_final = 1'b1;
              end
      RESP:   if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        type_q  <= req_type_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        err_q   <= acc_err;
        rdata_q <= '0;
      end
      if (cap_final) rdata_q <= load_data;
    end
  end

  // bus fields are forced to zero whenever no beat is being offered
  assign req_ready_o = (state_q == IDLE);
  assign mem_req_o   = (state_q == ISSUE) || (state_q == ISSUE2);
  assign mem_addr_o  = mem_req_o ? beat_addr : '0;
  assign mem_be_o    = mem_req_o ? beat_be : 4'b0000;
  assign mem_wdata_o = mem_req_o ? beat_wdata : '0;
  assign mem_we_o    = mem_req_o && is_store(type_q);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o && err_q;

endmodule

// File: tb/tb_lsu_access_controller.sv
// Directed bench for lsu_access_controller; works with or without LSU_MISALIGN_SPLIT_EN.
module tb_lsu_access_controller;

  localparam logic [3:0] L_B = 4'd0, L_BU = 4'd1, L_H = 4'd2, L_HU = 4'd3,
                         L_W = 4'd4, S_B = 4'd5, S_H = 4'd6, S_W = 4'd7, NOP = 4'hF;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [3:0]  req_type_i = '0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  lsu_access_controller #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_type_i(req_type_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Presents one request for a single cycle; returns in the cycle after acceptance.
  task automatic issue_req(input string tag, input logic [3:0] t, input logic [31:0] a, input logic [31:0] w);
    @(negedge clk_i);
    chk({tag, "_ready"}, req_ready_o, 1);
    req_valid_i = 1'b1;
    req_type_i  = t;
    req_addr_i  = a;
    req_wdata_i = w;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_type_i  = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    chk({tag, "_busy"}, req_ready_o, 0);
  endtask

  // One bus beat: grant after gnt_wait stalled cycles, then read data/ack the next cycle.
  task automatic mem_beat(input string tag, input int gnt_wait, input logic [31:0] e_addr,
                          input logic [3:0] e_be, input logic e_we, input logic [31:0] e_wdata,
                          input logic [31:0] rd);
    for (int i = 0; i <= gnt_wait; i++) begin
      chk({tag, "_req"}, mem_req_o, 1);
      chk({tag, "_addr"}, mem_addr_o, e_addr);
      chk({tag, "_be"}, mem_be_o, e_be);
      chk({tag, "_we"}, mem_we_o, e_we);
      chk({tag, "_wdata"}, mem_wdata_o, e_wdata);
      if (i == gnt_wait) mem_gnt_i = 1'b1;
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
    end
    chk({tag, "_req_drop"}, mem_req_o, 0);
    chk({tag, "_no_early_rsp"}, rsp_valid_o, 0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rd;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic resp(input string tag, input int ready_wait, input logic [31:0] e_rdata, input logic e_err);
    for (int i = 0; i <= ready_wait; i++) begin
      chk({tag, "_rsp_valid"}, rsp_valid_o, 1);
      chk({tag, "_rsp_rdata"}, rsp_rdata_o, e_rdata);
      chk({tag, "_rsp_err"}, rsp_err_o, e_err);
      chk({tag, "_rsp_ready_lo"}, req_ready_o, 0);
      if (i == ready_wait) rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
    end
    chk({tag, "_rsp_done"}, rsp_valid_o, 0);
    chk({tag, "_idle"}, req_ready_o, 1);
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_ready", req_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_be", mem_be_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 1: aligned word load, minimum latency
    issue_req("t1", L_W, 32'h100, 32'h0);
    mem_beat("t1", 0, 32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF);
    resp("t1", 0, 32'hDEADBEEF, 1'b0);

    // 2: byte loads from the top lane, signed and unsigned
    issue_req("t2s", L_B, 32'h103, 32'h0);
    mem_beat("t2s", 0, 32'h100, 4'b1000, 1'b0, 32'h0, 32'h80FFFFFF);
    resp("t2s", 0, 32'hFFFFFF80, 1'b0);
    issue_req("t2u", L_BU, 32'h103, 32'h0);
    mem_beat("t2u", 0, 32'h100, 4'b1000, 1'b0, 32'h0, 32'h80FFFFFF);
    resp("t2u", 0, 32'h00000080, 1'b0);

    // 3: halfword store into upper half
    issue_req("t3", S_H, 32'h202, 32'h1234ABCD);
    mem_beat("t3", 0, 32'h200, 4'b1100, 1'b1, 32'hABCD0000, 32'hFFFFFFFF);
    resp("t3", 0, 32'h0, 1'b0);

    // 4: stalled grant and stalled response consumer
    issue_req("t4", L_HU, 32'h302, 32'h0);
    mem_beat("t4", 3, 32'h300, 4'b1100, 1'b0, 32'h0, 32'h80017FFF);
    resp("t4", 2, 32'h00008001, 1'b0);
    issue_req("t4b", S_B, 32'h101, 32'h000000A5);
    mem_beat("t4b", 1, 32'h100, 4'b0010, 1'b1, 32'h0000A500, 32'h0);
    resp("t4b", 1, 32'h0, 1'b0);
    issue_req("t4c", L_H, 32'h100, 32'h0);
    mem_beat("t4c", 0, 32'h100, 4'b0011, 1'b0, 32'h0, 32'h12348765);
    resp("t4c", 0, 32'hFFFF8765, 1'b0);

    // 5: misaligned word load and a non-memory type
`ifdef LSU_MISALIGN_SPLIT_EN
    issue_req("t5", L_W, 32'h101, 32'h0);
    mem_beat("t5b1", 0, 32'h100, 4'b1110, 1'b0, 32'h0, 32'h44332211);
    mem_beat("t5b2", 0, 32'h104, 4'b0001, 1'b0, 32'h0, 32'h88776655);
    resp("t5", 0, 32'h55443322, 1'b0);
    issue_req("t5w", S_W, 32'hFFFFFFFE, 32'hAABBCCDD);
    mem_beat("t5wb1", 0, 32'hFFFFFFFC, 4'b1100, 1'b1, 32'hCCDD0000, 32'h0);
    mem_beat("t5wb2", 0, 32'h00000000, 4'b0011, 1'b1, 32'h0000AABB, 32'h0);
    resp("t5w", 0, 32'h0, 1'b0);
`else
    issue_req("t5", L_W, 32'h101, 32'h0);
    chk("t5_no_mem_req", mem_req_o, 0);
    resp("t5", 0, 32'h0, 1'b1);
    issue_req("t5h", L_H, 32'h103, 32'h0);
    chk("t5h_no_mem_req", mem_req_o, 0);
    resp("t5h", 0, 32'h0, 1'b1);
`endif
    issue_req("t5n", NOP, 32'h100, 32'h0);
    chk("t5n_no_mem_req", mem_req_o, 0);
    resp("t5n", 0, 32'h0, 1'b1);

    // 6a: reset while a beat is being offered drops the request at once
    issue_req("t6a", L_W, 32'h100, 32'h0);
    chk("t6a_req", mem_req_o, 1);
    #2 rst_ni = 1'b0;
    #1 chk("t6a_req_async_drop", mem_req_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 6b: reset in WAIT, late rvalid after release is ignored
    issue_req("t6", L_W, 32'h100, 32'h0);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    chk("t6_in_wait", mem_req_o, 0);
    rst_ni = 1'b0;
    #1 chk("t6_rst_ready", req_ready_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h12345678;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    chk("t6_no_rsp", rsp_valid_o, 0);
    chk("t6_ready", req_ready_o, 1);
    chk("t6_no_req", mem_req_o, 0);
    @(negedge clk_i);
    chk("t6_no_rsp2", rsp_valid_o, 0);

    // still functional after the abort
    issue_req("t7", L_B, 32'h102, 32'h0);
    mem_beat("t7", 1, 32'h100, 4'b0100, 1'b0, 32'h0, 32'h00700000);
    resp("t7", 0, 32'h00000070, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
